// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch hazards, data-memory wait FSM with timeout fault
// Forwarding is purely combinational; stalls/flushes come from a RUN/MEM_WAIT/ERR FSM.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_loaduse;
  logic       w_branch;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;

  // M-stage result is younger than W-stage, so it wins on a double match.
  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      w_fwd_a = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      w_fwd_b = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      w_fwd_b = 2'b01;
  end

  assign w_loaduse = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    w_next    = r_state;
    w_branch  = 1'b0;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    case (r_state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          w_next    = MEM_WAIT;
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
        end else if (PCSrcE) begin
          w_branch  = 1'b1;
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_loaduse) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Memory stage is released in the completion cycle so the access retires.
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = !dmem_ready;
        if (dmem_ready)
          w_next = RUN;
        else if (r_wait_cnt == TO_M1)
          w_next = ERR;
      end
      ERR: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state       <= w_next;
      r_mem_timeout <= r_mem_timeout | (w_next == ERR);
      if ((r_state == RUN) && (w_next == MEM_WAIT))
        r_wait_cnt <= 8'd0;
      else if (r_state == MEM_WAIT)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_stall_f && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_branch && (r_flush_events != '1))
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  // Combinational outputs are held quiet for as long as reset is asserted.
  assign ForwardAE    = rst ? w_fwd_a : 2'b00;
  assign ForwardBE    = rst ? w_fwd_b : 2'b00;
  assign StallF       = rst & w_stall_f;
  assign StallD       = rst & w_stall_d;
  assign StallE       = rst & w_stall_e;
  assign StallM       = rst & w_stall_m;
  assign FlushD       = rst & w_flush_d;
  assign FlushE       = rst & w_flush_e;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, dmem_req, dmem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [15:0] stall_cycles, flush_events;
  logic [5:0]  hz;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  assign hz = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RdM = 5'd3; RegWriteM = 1; Rs1E = 5'd3; Rs2E = 5'd3; PCSrcE = 1;
    dmem_req = 1;
    rst = 1'b0;
    #3;
    checks++;
    if (hz !== 6'b000000) begin
      $display("FAIL reset_hz got %b exp 000000", hz); errors++;
    end
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      $display("FAIL reset_fwd got %b exp 0000", {ForwardAE, ForwardBE}); errors++;
    end
    checks++;
    if ({mem_timeout, stall_cycles, flush_events} !== 33'd0) begin
      $display("FAIL reset_regs got %0h exp 0", {mem_timeout, stall_cycles, flush_events}); errors++;
    end
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_forwarding();
    pulse_reset();
    clear_inputs();
    RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      $display("FAIL fwd_m_prio got %b exp 1000", {ForwardAE, ForwardBE}); errors++;
    end
    RegWriteM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      $display("FAIL fwd_w got %b exp 01", ForwardAE); errors++;
    end
    RdM = 5'd0; RegWriteM = 1; RdW = 5'd9; Rs1E = 5'd0; Rs2E = 5'd9;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      $display("FAIL fwd_zero_b_w got %b exp 0001", {ForwardAE, ForwardBE}); errors++;
    end
    RdM = 5'd9;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      $display("FAIL fwd_b_m got %b exp 0010", {ForwardAE, ForwardBE}); errors++;
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    pulse_reset();
    clear_inputs();
    ResultSrcE = 1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    checks++;
    if (hz !== 6'b110001) begin
      $display("FAIL loaduse_hz got %b exp 110001", hz); errors++;
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (hz !== 6'b000000) begin
      $display("FAIL loaduse_one_cycle got %b exp 000000", hz); errors++;
    end
    checks++;
    if (stall_cycles !== 16'd1) begin
      $display("FAIL loaduse_cnt got %0d exp 1", stall_cycles); errors++;
    end
    ResultSrcE = 1; RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
    #1;
    checks++;
    if (hz !== 6'b000000) begin
      $display("FAIL loaduse_r0 got %b exp 000000", hz); errors++;
    end
    tick();
    checks++;
    if (stall_cycles !== 16'd1) begin
      $display("FAIL loaduse_r0_cnt got %0d exp 1", stall_cycles); errors++;
    end
    clear_inputs();
  endtask

  task automatic test_branch_over_loaduse();
    pulse_reset();
    clear_inputs();
    ResultSrcE = 1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1;
    #1;
    checks++;
    if (hz !== 6'b000011) begin
      $display("FAIL branch_hz got %b exp 000011", hz); errors++;
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({flush_events, stall_cycles} !== {16'd1, 16'd0}) begin
      $display("FAIL branch_cnt got flush %0d stall %0d exp 1 0", flush_events, stall_cycles); errors++;
    end
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    clear_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (hz !== 6'b111100) begin
        $display("FAIL memwait_c%0d got %b exp 111100", i, hz); errors++;
      end
      tick();
    end
    dmem_ready = 1; PCSrcE = 1;
    #1;
    checks++;
    if (hz !== 6'b111000) begin
      $display("FAIL memwait_exit got %b exp 111000", hz); errors++;
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (hz !== 6'b000000) begin
      $display("FAIL memwait_run got %b exp 000000", hz); errors++;
    end
    checks++;
    if ({stall_cycles, flush_events} !== {16'd4, 16'd0}) begin
      $display("FAIL memwait_cnt got stall %0d flush %0d exp 4 0", stall_cycles, flush_events); errors++;
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    clear_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (mem_timeout !== 1'b0) begin
      $display("FAIL timeout_early got %b exp 0", mem_timeout); errors++;
    end
    tick();
    checks++;
    if ({mem_timeout, hz} !== 7'b1111100) begin
      $display("FAIL timeout_err got %b exp 1111100", {mem_timeout, hz}); errors++;
    end
    dmem_req = 0; PCSrcE = 1; ResultSrcE = 1; RdE = 5'd2; Rs1D = 5'd2;
    tick();
    checks++;
    if ({mem_timeout, hz} !== 7'b1111100) begin
      $display("FAIL timeout_absorb got %b exp 1111100", {mem_timeout, hz}); errors++;
    end
    clear_inputs();
    PCSrcE = 1;
    rst = 1'b0;
    #2;
    checks++;
    if ({mem_timeout, hz, ForwardAE, ForwardBE} !== 11'd0) begin
      $display("FAIL timeout_rst_out got %b exp 0", {mem_timeout, hz, ForwardAE, ForwardBE}); errors++;
    end
    checks++;
    if ({stall_cycles, flush_events} !== 32'd0) begin
      $display("FAIL timeout_rst_cnt got %0d %0d exp 0 0", stall_cycles, flush_events); errors++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (hz !== 6'b000011) begin
      $display("FAIL post_rst_run got %b exp 000011", hz); errors++;
    end
    tick();
    checks++;
    if ({flush_events, mem_timeout} !== {16'd1, 1'b0}) begin
      $display("FAIL post_rst_edge got flush %0d to %b exp 1 0", flush_events, mem_timeout); errors++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_loaduse();
    test_mem_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
